// File: rtl/ct_lsu_sf_chk_arb.sv
// Two-pipe arbiter for the single-ported LSU spec-fail predictor: one issue per cycle,
// one-entry park buffer, post-flush blackout. Optional stall counter: LSU_SF_ARB_PERF_EN.
module ct_lsu_sf_chk_arb #(
  parameter int unsigned FLUSH_BLK = 2
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        rtu_yy_xx_flush,
  input  logic        ld0_sf_chk_req,
  input  logic [35:0] ld0_sf_addr_tto4,
  input  logic [15:0] ld0_sf_bytes_vld,
  input  logic [6:0]  ld0_sf_iid,
  input  logic        ld1_sf_chk_req,
  input  logic [35:0] ld1_sf_addr_tto4,
  input  logic [15:0] ld1_sf_bytes_vld,
  input  logic [6:0]  ld1_sf_iid,
  output logic        ld0_sf_chk_stall,
  output logic        ld1_sf_chk_stall,
  output logic        sf_ld_chk_req,
  output logic [35:0] sf_ld_addr_tto4,
  output logic [15:0] sf_ld_bytes_vld,
  input  logic        sf_spec_hit,
  input  logic        sf_spec_mark,
  output logic        ld0_sf_resp_vld,
  output logic        ld0_sf_resp_hit,
  output logic        ld0_sf_resp_mark,
  output logic [6:0]  ld0_sf_resp_iid,
  output logic        ld1_sf_resp_vld,
  output logic        ld1_sf_resp_hit,
  output logic        ld1_sf_resp_mark,
  output logic [6:0]  ld1_sf_resp_iid
`ifdef LSU_SF_ARB_PERF_EN
  ,
  output logic [15:0] sf_arb_stall_cnt
`endif
);

  typedef struct packed {
    logic [35:0] addr;
    logic [15:0] bytes;
    logic [6:0]  iid;
  } chk_t;

  chk_t       new_chk [2];
  logic [1:0] req;
  logic [1:0] take;
  logic [1:0] park;
  logic [1:0] stall;

  logic       pnd_vld_q, pnd_vld_d;
  logic       pnd_src_q, pnd_src_d;
  chk_t       pnd_q, pnd_d;
  logic       rr_q, rr_d;
  logic [2:0] blk_q, blk_d;

  logic       issue_vld;
  logic       issue_src;
  chk_t       issue_chk;

  logic [1:0] resp_vld_q, resp_hit_q, resp_mark_q;
  logic [6:0] resp_iid_q [2];

  assign req        = {ld1_sf_chk_req, ld0_sf_chk_req};
  assign new_chk[0] = '{addr: ld0_sf_addr_tto4, bytes: ld0_sf_bytes_vld, iid: ld0_sf_iid};
  assign new_chk[1] = '{addr: ld1_sf_addr_tto4, bytes: ld1_sf_bytes_vld, iid: ld1_sf_iid};

  // NOTE: every variable gets a default first so no path through the if/else leaves a latch.
  always_comb begin
    issue_vld = 1'b0;
    issue_src = 1'b0;
    issue_chk = '0;
    take      = 2'b00;
    park      = 2'b00;
    pnd_vld_d = pnd_vld_q;
    pnd_src_d = pnd_src_q;
    pnd_d     = pnd_q;
    rr_d      = rr_q;
    blk_d     = blk_q;

    if (rtu_yy_xx_flush) begin
      pnd_vld_d = 1'b0;
      blk_d     = 3'(FLUSH_BLK);
    end else if (blk_q != 3'd0) begin
      blk_d = blk_q - 3'd1;
    end else begin
      if (pnd_vld_q) begin
        issue_vld = 1'b1;
        issue_src = pnd_src_q;
        issue_chk = pnd_q;
        pnd_vld_d = 1'b0;
        if (req[rr_q])       park[rr_q]  = 1'b1;
        else if (req[~rr_q]) park[~rr_q] = 1'b1;
      end else if (req[rr_q]) begin
        issue_vld  = 1'b1;
        issue_src  = rr_q;
        issue_chk  = new_chk[rr_q];
        take[rr_q] = 1'b1;
        if (req[~rr_q]) park[~rr_q] = 1'b1;
      end else if (req[~rr_q]) begin
        issue_vld   = 1'b1;
        issue_src   = ~rr_q;
        issue_chk   = new_chk[~rr_q];
        take[~rr_q] = 1'b1;
      end
      if (park != 2'b00) begin
        pnd_vld_d = 1'b1;
        pnd_src_d = park[1];
        pnd_d     = new_chk[park[1]];
      end
      // Loser of a two-way contest becomes preferred next time.
      if (&req) rr_d = ~rr_q;
    end

    stall = req & ~take & ~park & {2{~rtu_yy_xx_flush}};
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      pnd_vld_q <= 1'b0;
      pnd_src_q <= 1'b0;
      rr_q      <= 1'b0;
      blk_q     <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pnd_vld_q <= pnd_vld_d;
      pnd_src_q <= pnd_src_d;
      rr_q      <= rr_d;
      blk_q     <= blk_d;
    end
  end

  // NOTE: the pending payload is only ever read under pnd_vld_q, so it needs no reset.
  always_ff @(posedge forever_cpuclk) begin
    pnd_q <= pnd_d;
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      resp_vld_q    <= 2'b00;
      resp_hit_q    <= 2'b00;
      resp_mark_q   <= 2'b00;
      resp_iid_q[0] <= 7'd0;
      resp_iid_q[1] <= 7'd0;
    end else begin
      resp_vld_q <= 2'b00;
      if (issue_vld) begin
        resp_vld_q[issue_src]  <= 1'b1;
        resp_hit_q[issue_src]  <= sf_spec_hit;
        resp_mark_q[issue_src] <= sf_spec_mark;
        resp_iid_q[issue_src]  <= issue_chk.iid;
      end
    end
  end

`ifdef LSU_SF_ARB_PERF_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst)                                stall_cnt_q <= 16'd0;
    else if (|stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end
  assign sf_arb_stall_cnt = stall_cnt_q;
`endif

  assign ld0_sf_chk_stall = stall[0];
  assign ld1_sf_chk_stall = stall[1];
  assign sf_ld_chk_req    = issue_vld;
  assign sf_ld_addr_tto4  = issue_chk.addr;
  assign sf_ld_bytes_vld  = issue_chk.bytes;
  assign ld0_sf_resp_vld  = resp_vld_q[0];
  assign ld0_sf_resp_hit  = resp_hit_q[0];
  assign ld0_sf_resp_mark = resp_mark_q[0];
  assign ld0_sf_resp_iid  = resp_iid_q[0];
  assign ld1_sf_resp_vld  = resp_vld_q[1];
  assign ld1_sf_resp_hit  = resp_hit_q[1];
  assign ld1_sf_resp_mark = resp_mark_q[1];
  assign ld1_sf_resp_iid  = resp_iid_q[1];

endmodule

// File: doc/ct_lsu_sf_chk_arb.md
# ct_lsu_sf_chk_arb

Arbiter and sequencer that shares the single-ported LSU speculative-fail predictor between load pipe 0 and load pipe 1 during DA-stage spec-fail checks. It grants one load check per cycle, parks one losing request in a one-entry pending buffer, and stalls any request it can neither serve nor park. After every pipeline flush it enforces a blackout window. It also returns each granted pipe's predictor hit/mark result as a registered response.

## Interface
Parameters:
- FLUSH_BLK, default 2: cycles after `rtu_yy_xx_flush` during which no check is issued (range 0..7).

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  reset; asynchronous, active-high.
- rtu_yy_xx_flush  in  1  pipeline flush.
- ld0_sf_chk_req / ld1_sf_chk_req  in  1  pipe N requests a spec-fail check this cycle.
- ld0_sf_addr_tto4 / ld1_sf_addr_tto4  in  36  PA[39:4] of pipe N's load.
- ld0_sf_bytes_vld / ld1_sf_bytes_vld  in  16  byte mask of pipe N's load.
- ld0_sf_iid / ld1_sf_iid  in  7  IID of pipe N's load.
- ld0_sf_chk_stall / ld1_sf_chk_stall  out  1  request not accepted; the pipe holds it and replays it next cycle.
- sf_ld_chk_req  out  1  check issued to the predictor.
- sf_ld_addr_tto4  out  36  address of the issued check.
- sf_ld_bytes_vld  out  16  byte mask of the issued check.
- sf_spec_hit, sf_spec_mark  in  1  predictor results, combinational on `sf_ld_*`.
- ld0_sf_resp_vld / ld1_sf_resp_vld  out  1  registered response for pipe N.
- ld0_sf_resp_hit / ld1_sf_resp_hit, ld0_sf_resp_mark / ld1_sf_resp_mark  out  1  registered hit and mark for pipe N.
- ld0_sf_resp_iid / ld1_sf_resp_iid  out  7  echoed IID of the responded request.
- sf_arb_stall_cnt  out  16  stall statistics; exists only with the macro (see Configuration).

## Operation
- State:
  - pending entry: pnd_vld, pnd_src, addr, bytes, iid.
  - rr_ptr: preferred pipe; reset 0 = pipe 0.
  - blk_cnt[2:0]: blackout counter.
- Flush cycle (`rtu_yy_xx_flush`=1):
  - `sf_ld_chk_req`=0 and both stalls=0; the pipes are flushed too.
  - pnd_vld cleared.
  - blk_cnt loaded with FLUSH_BLK.
  - rr_ptr unchanged.
- Blackout (blk_cnt≠0, no flush):
  - nothing issued.
  - every new request stalled.
  - blk_cnt decrements by 1 each cycle.
- Normal cycle, pnd_vld=1:
  - The pending entry is issued.
  - At most one new request is parked: the rr_ptr pipe if it requests, otherwise the other pipe.
  - Any remaining new request is stalled.
- Normal cycle, pnd_vld=0:
  - A single request is issued.
  - With two requests, the rr_ptr pipe is issued and the other is parked.
  - No stall in this case.
- rr_ptr toggles only in a cycle where both pipes present new requests and neither is stalled by blackout or flush; the loser becomes preferred.
- Stall definition: `ldN_sf_chk_stall` = req & ~issued & ~parked & ~flush.
- Response registers:
  - When a check issues in cycle T, the issued source's `resp_vld` is 1 in cycle T+1.
  - The `resp_hit`, `resp_mark` and `resp_iid` values sampled at T are also presented in T+1.
  - The other pipe's `resp_vld` is 0.
  - `resp_vld` is a 1-cycle pulse. A flush in T+1 does not retract it; the consumer drops it.
- Reset values: all outputs 0, pnd_vld=0, rr_ptr=0, blk_cnt=0.
- Reset mid-operation discards the pending entry and any in-flight response.

## Timing
- Issue path is combinational, from `ldN_sf_chk_req` / pending state to `sf_ld_*`.
- Response latency is exactly 1 cycle after issue.
- A parked request issues in the cycle after it is parked, unless a flush intervenes.
- The worst case for a stalled pipe that replays continuously is 2 cycles to acceptance, outside blackout.
- Blackout lasts exactly FLUSH_BLK cycles after the flush cycle. With FLUSH_BLK=0, issue resumes in the cycle following the flush.

## Configuration
- LSU_SF_ARB_PERF_EN defined:
  - `sf_arb_stall_cnt` is a 16-bit saturating counter, reset 0.
  - Increments by 1 in each cycle where either stall is 1; by 1, not 2, when both stall.
  - Holds at 0xFFFF.
  - Not cleared by flush.
- LSU_SF_ARB_PERF_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Single request: ld0 requests (addr 0x123456789, bytes 0x00F0, iid 5) with predictor hit=1 -> `sf_ld_chk_req`=1 the same cycle; next cycle `ld0_sf_resp_vld`=1, hit=1, iid=5; no stall.
- Contention from reset: both pipes request with iids 3 and 9 -> ld0 issues, ld1 is parked; ld1 issues the next cycle; responses for iid 3 then iid 9 in consecutive cycles; rr_ptr=1.
- Back-to-back contention: both request for 3 consecutive cycles -> cycle 2 issues the pending entry, parks the rr_ptr pipe and stalls the other; stall count sequence 0,1,1 per cycle.
- Flush with a pending entry: a flush arrives while pnd_vld=1 and FLUSH_BLK=2 -> no issue for 3 cycles (flush cycle plus 2); any requests in the 2 blackout cycles are stalled; the pending entry never issues.
- Perf counter (macro on): force 0x10000 stall cycles -> `sf_arb_stall_cnt` saturates at 0xFFFF; apply cpurst -> 0.
- Reset mid-operation: assert cpurst in the cycle after an issue -> `resp_vld` and all outputs read 0 immediately; no response appears after reset releases.
